// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: byte/half/word access, big-endian lanes, RMW sub-word stores.
// Define MEM_ACCESS_BOUNDS_CHECK_EN to fault requests with req_addr[31:ADDR_BITS] != 0.
module mem_access_unit #(
    parameter int ADDR_BITS = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        exc_valid,
    output logic [1:0]  exc_cause,
    output logic [31:0] exc_addr,
    output logic        dm_read,
    output logic        dm_write,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata
);

`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
    localparam bit BoundsEn = 1'b1;
`else
    localparam bit BoundsEn = 1'b0;
`endif

    typedef enum logic {IDLE, RMW_WR} state_e;

    state_e      state_q, state_d;
    logic [31:0] rmw_addr_q, rmw_addr_d;
    logic [31:0] rmw_data_q, rmw_data_d;
    logic        rsp_valid_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        exc_valid_d;
    logic [1:0]  exc_cause_q, exc_cause_d;
    logic [31:0] exc_addr_q, exc_addr_d;

    logic        is_byte, is_half, misalign, oob, fault;
    logic [1:0]  off;
    logic [31:0] word_addr, ld_ext, merged;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        is_byte   = (req_size == 2'b00);
        is_half   = (req_size == 2'b01);
        off       = req_addr[1:0];
        misalign  = (is_half & off[0]) | (~is_byte & ~is_half & (|off));
        oob       = BoundsEn & (|req_addr[31:ADDR_BITS]);
        fault     = misalign | oob;
        word_addr = {req_addr[31:2], 2'b00};
    end

    // Big-endian lanes: offset 0 is the most significant byte.
    always_comb begin
        ld_byte = dm_rdata[{~off, 3'b000} +: 8];
        ld_half = dm_rdata[{~off[1], 4'b0000} +: 16];
        merged  = dm_rdata;
        if (is_byte) begin
            merged[{~off, 3'b000} +: 8] = req_wdata[7:0];
        end else begin
            merged[{~off[1], 4'b0000} +: 16] = req_wdata[15:0];
        end
        unique case (1'b1)
            is_byte: ld_ext = {{24{~req_unsigned & ld_byte[7]}}, ld_byte};
            is_half: ld_ext = {{16{~req_unsigned & ld_half[15]}}, ld_half};
            default: ld_ext = dm_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        rmw_addr_d  = rmw_addr_q;
        rmw_data_d  = rmw_data_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        exc_valid_d = 1'b0;
        exc_cause_d = exc_cause_q;
        exc_addr_d  = exc_addr_q;
        req_ready   = 1'b0;
        dm_read     = 1'b0;
        dm_write    = 1'b0;
        dm_addr     = 32'h0;
        dm_wdata    = 32'h0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (fault) begin
                        exc_valid_d = 1'b1;
                        exc_cause_d = misalign ? (req_we ? 2'b10 : 2'b01) : 2'b11;
                        exc_addr_d  = req_addr;
                    end else if (!req_we) begin
                        dm_read     = 1'b1;
                        dm_addr     = word_addr;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = ld_ext;
                    end else if (is_byte || is_half) begin
                        req_ready  = 1'b0;
                        dm_read    = 1'b1;
                        dm_addr    = word_addr;
                        rmw_addr_d = word_addr;
                        rmw_data_d = merged;
                        state_d    = RMW_WR;
                    end else begin
                        dm_write = 1'b1;
                        dm_addr  = word_addr;
                        dm_wdata = req_wdata;
                    end
                end
            end
            RMW_WR: begin
                req_ready = 1'b1;
                dm_write  = 1'b1;
                dm_addr   = rmw_addr_q;
                dm_wdata  = rmw_data_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Memory must see nothing while reset is held, even mid-RMW.
        if (!rst_n) begin
            dm_read  = 1'b0;
            dm_write = 1'b0;
            dm_addr  = 32'h0;
            dm_wdata = 32'h0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rmw_addr_q  <= 32'h0;
            rmw_data_q  <= 32'h0;
            rsp_valid   <= 1'b0;
            rsp_data_q  <= 32'h0;
            exc_valid   <= 1'b0;
            exc_cause_q <= 2'b00;
            exc_addr_q  <= 32'h0;
        end else begin
            state_q     <= state_d;
            rmw_addr_q  <= rmw_addr_d;
            rmw_data_q  <= rmw_data_d;
            rsp_valid   <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            exc_valid   <= exc_valid_d;
            exc_cause_q <= exc_cause_d;
            exc_addr_q  <= exc_addr_d;
        end
    end

    assign rsp_data  = rsp_data_q;
    assign exc_cause = exc_cause_q;
    assign exc_addr  = exc_addr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural data memory and response scoreboard.
module tb_mem_access_unit;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        exc_valid;
    logic [1:0]  exc_cause;
    logic [31:0] exc_addr;
    logic        dm_read;
    logic        dm_write;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;

    logic [31:0] mem [0:255] = '{default: 32'h0};

    typedef struct {
        bit          is_exc;
        logic [31:0] data;
        logic [1:0]  cause;
        logic [31:0] addr;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    assign dm_rdata = mem[dm_addr[9:2]];
    always @(posedge clk) if (dm_write) mem[dm_addr[9:2]] <= dm_wdata;

    mem_access_unit #(.ADDR_BITS(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_addr(exc_addr),
        .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
    endtask

    task automatic go();
        bit ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("handshake", {31'b0, ok}, 32'h1);
        @(posedge clk);
        #1;
    endtask

    task automatic push_rsp(input logic [31:0] d);
        exp_t e;
        e.is_exc = 1'b0; e.data = d; e.cause = 2'b00; e.addr = 32'h0;
        sb.push_back(e);
    endtask

    task automatic push_exc(input logic [1:0] c, input logic [31:0] a);
        exp_t e;
        e.is_exc = 1'b1; e.data = 32'h0; e.cause = c; e.addr = a;
        sb.push_back(e);
    endtask

    task automatic load(input logic [1:0] sz, input logic uns, input logic [31:0] a,
                        input logic [31:0] exp);
        drv(1'b0, sz, uns, a, 32'h0);
        push_rsp(exp);
        go();
    endtask

    task automatic idle_cycles(input int n);
        req_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && (rsp_valid || exc_valid)) begin
            exp_t e;
            chk("pulse_excl", {31'b0, rsp_valid & exc_valid}, 32'h0);
            chk("sb_nonempty", {31'b0, sb.size() != 0}, 32'h1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("out_kind", {31'b0, exc_valid}, {31'b0, e.is_exc});
                if (e.is_exc) begin
                    chk("exc_cause", {30'b0, exc_cause}, {30'b0, e.cause});
                    chk("exc_addr", exc_addr, e.addr);
                end else begin
                    chk("rsp_data", rsp_data, e.data);
                end
            end
        end
    end

    initial begin
        // Reset: a store presented during reset must not reach memory.
        drv(1'b1, SZ_W, 1'b0, 32'h10, 32'hFFFF_FFFF);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dm_write", {31'b0, dm_write}, 32'h0);
        chk("rst_dm_read", {31'b0, dm_read}, 32'h0);
        chk("rst_dm_addr", dm_addr, 32'h0);
        chk("rst_dm_wdata", dm_wdata, 32'h0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_exc_valid", {31'b0, exc_valid}, 32'h0);
        chk("rst_exc_cause", {30'b0, exc_cause}, 32'h0);
        chk("rst_exc_addr", exc_addr, 32'h0);
        req_valid = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Idle outputs
        @(negedge clk);
        chk("idle_dm_read", {31'b0, dm_read}, 32'h0);
        chk("idle_dm_addr", dm_addr, 32'h0);
        @(posedge clk);
        #1;

        // Word stores
        drv(1'b1, SZ_W, 1'b0, 32'h0, 32'h0123_4567);
        go();
        drv(1'b1, SZ_W, 1'b0, 32'h10, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("sw_ready", {31'b0, req_ready}, 32'h1);
        chk("sw_dm_write", {31'b0, dm_write}, 32'h1);
        chk("sw_dm_read", {31'b0, dm_read}, 32'h0);
        chk("sw_dm_addr", dm_addr, 32'h10);
        chk("sw_dm_wdata", dm_wdata, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("sw_one_cycle", {31'b0, dm_write}, 32'h0);
        @(posedge clk);
        #1;

        // Word load, dm access checked in its issue cycle
        drv(1'b0, SZ_W, 1'b1, 32'h10, 32'h0);
        push_rsp(32'hDEAD_BEEF);
        @(negedge clk);
        chk("lw_dm_read", {31'b0, dm_read}, 32'h1);
        chk("lw_dm_addr", dm_addr, 32'h10);
        @(posedge clk);
        #1;

        // Byte RMW store
        drv(1'b1, SZ_B, 1'b0, 32'h13, 32'h0000_00AA);
        @(negedge clk);
        chk("sb_rd_ready", {31'b0, req_ready}, 32'h0);
        chk("sb_rd_read", {31'b0, dm_read}, 32'h1);
        chk("sb_rd_write", {31'b0, dm_write}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("sb_wr_ready", {31'b0, req_ready}, 32'h1);
        chk("sb_wr_write", {31'b0, dm_write}, 32'h1);
        chk("sb_wr_read", {31'b0, dm_read}, 32'h0);
        chk("sb_wr_addr", dm_addr, 32'h10);
        chk("sb_wr_wdata", dm_wdata, 32'hDEAD_BEAA);
        @(posedge clk);
        #1;
        // Load immediately after RMW_WR sees the merged word
        load(SZ_B, 1'b0, 32'h13, 32'hFFFF_FFAA);
        load(SZ_B, 1'b1, 32'h13, 32'h0000_00AA);
        load(SZ_B, 1'b0, 32'h10, 32'hFFFF_FFDE);
        load(SZ_B, 1'b1, 32'h11, 32'h0000_00AD);
        load(SZ_B, 1'b0, 32'h12, 32'hFFFF_FFBE);

        // Halfword RMW store then loads back-to-back
        drv(1'b1, SZ_H, 1'b0, 32'h12, 32'h0000_1234);
        @(negedge clk);
        chk("sh_rd_ready", {31'b0, req_ready}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("sh_wr_wdata", dm_wdata, 32'hDEAD_1234);
        @(posedge clk);
        #1;
        load(SZ_H, 1'b0, 32'h10, 32'hFFFF_DEAD);
        load(SZ_H, 1'b1, 32'h12, 32'h0000_1234);
        load(SZ_H, 1'b1, 32'h10, 32'h0000_DEAD);
        load(SZ_H, 1'b0, 32'h12, 32'h0000_1234);
        load(2'b11, 1'b0, 32'h10, 32'hDEAD_1234);

        // Misalignment
        drv(1'b0, SZ_W, 1'b0, 32'h11, 32'h0);
        push_exc(2'b01, 32'h11);
        @(negedge clk);
        chk("mis_ready", {31'b0, req_ready}, 32'h1);
        chk("mis_dm_read", {31'b0, dm_read}, 32'h0);
        chk("mis_dm_write", {31'b0, dm_write}, 32'h0);
        @(posedge clk);
        #1;
        drv(1'b1, SZ_H, 1'b0, 32'h13, 32'h0000_5555);
        push_exc(2'b10, 32'h13);
        @(negedge clk);
        chk("mis_sh_ready", {31'b0, req_ready}, 32'h1);
        chk("mis_sh_read", {31'b0, dm_read}, 32'h0);
        @(posedge clk);
        #1;
        drv(1'b0, SZ_H, 1'b1, 32'h11, 32'h0);
        push_exc(2'b01, 32'h11);
        go();
        drv(1'b1, SZ_W, 1'b0, 32'h2, 32'h0);
        push_exc(2'b10, 32'h2);
        go();
        load(SZ_W, 1'b0, 32'h10, 32'hDEAD_1234);
        idle_cycles(2);

        // Reset asserted while in RMW_WR aborts the write
        drv(1'b1, SZ_B, 1'b0, 32'h10, 32'h0000_0055);
        @(negedge clk);
        chk("rr_rd_ready", {31'b0, req_ready}, 32'h0);
        @(posedge clk);
        #1;
        chk("rr_in_wr", {31'b0, dm_write}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rr_dm_write", {31'b0, dm_write}, 32'h0);
        chk("rr_dm_addr", dm_addr, 32'h0);
        req_valid = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        load(SZ_W, 1'b0, 32'h10, 32'hDEAD_1234);

        // Bounds: misalignment wins, then the bounds behaviour of this build
        drv(1'b0, SZ_W, 1'b0, 32'h401, 32'h0);
        push_exc(2'b01, 32'h401);
        go();
`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
        drv(1'b0, SZ_W, 1'b0, 32'h400, 32'h0);
        push_exc(2'b11, 32'h400);
        @(negedge clk);
        chk("oob_dm_read", {31'b0, dm_read}, 32'h0);
        @(posedge clk);
        #1;
`else
        load(SZ_W, 1'b0, 32'h400, 32'h0123_4567);
`endif
        idle_cycles(3);
        chk("sb_drained", sb.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store unit placed directly upstream of the word-addressed data memory. It drives that memory's read, write, address and write-data inputs, and consumes its combinational read data.
- Converts pipeline byte/halfword/word load and store requests into word accesses.
- Byte and halfword stores use a two-cycle read-modify-write.
- Loads are extracted and extended from the returned word.
- Misaligned requests are detected and reported as exceptions.

Parameters:
- ADDR_BITS, 10: byte-address width decoded by data memory (256 words).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- req_valid  in  1  pipeline presents a memory request.
- req_ready  out  1  request accepted this cycle when req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  one-cycle pulse: load result valid.
- rsp_data  out  32  extended load result.
- exc_valid  out  1  one-cycle pulse: request faulted.
- exc_cause  out  2  01 misaligned load, 10 misaligned store, 11 out of bounds.
- exc_addr  out  32  faulting byte address.
- dm_read  out  1  to data memory.
- dm_write  out  1  to data memory.
- dm_addr  out  32  word-aligned address to data memory (bits 1:0 = 0).
- dm_wdata  out  32  to data memory.
- dm_rdata  in  32  combinational read data from data memory.

Behaviour:
- Byte order is big-endian: offset 0 maps to bits 31:24, offset 3 to bits 7:0. Half offset 0 maps to bits 31:16, offset 2 to bits 15:0.
- FSM has two states: IDLE and RMW_WR.
- Reset:
  - State returns to IDLE.
  - rsp_valid, rsp_data, exc_valid, exc_cause and exc_addr are 0.
  - The dm_* outputs are 0 while rst_n is low.
- Alignment rule: halfword requires addr[0] = 0; word requires addr[1:0] = 0. A failing request is accepted with req_ready = 1 and makes no dm access. On the next cycle exc_valid = 1, exc_cause = 01 for a load or 10 for a store, and exc_addr = req_addr. rsp_valid stays 0.
- IDLE, word store: req_ready = 1. In the same cycle dm_write = 1, dm_addr = {addr[31:2], 00}, dm_wdata = req_wdata. Memory updates on that edge.
- IDLE, load:
  - In the same cycle req_ready = 1, dm_read = 1 and dm_addr is word-aligned.
  - The byte or half lane selected by addr[1:0] is extended per req_unsigned and registered.
  - rsp_valid and rsp_data appear on the next cycle (latency 1).
  - Word loads ignore req_unsigned.
- IDLE, byte/half store:
  - req_ready = 0 and dm_read = 1.
  - The unit registers the word address and the merged word: dm_rdata with the addressed lane replaced by req_wdata[7:0] or req_wdata[15:0].
  - Next state is RMW_WR.
- RMW_WR:
  - dm_write = 1, dm_read = 0, dm_addr and dm_wdata come from registers.
  - req_ready = 1, so the still-presented store is consumed and not re-executed.
  - Next state is IDLE.
- A load in the cycle immediately after RMW_WR observes the merged word.
- dm_read and dm_write are never high together.
- With no valid request in IDLE: dm_read = 0, dm_write = 0, dm_addr = 0, dm_wdata = 0.
- rsp_valid and exc_valid are single-cycle pulses and never high together.
- Reset asserted in RMW_WR: the state returns to IDLE immediately, dm_write drops, and memory is not written.

Optional Feature:
- Macro MEM_ACCESS_BOUNDS_CHECK_EN.
- When defined: an aligned request with req_addr[31:ADDR_BITS] != 0 is accepted without dm access. On the next cycle exc_valid = 1, exc_cause = 11, exc_addr = req_addr. Misalignment takes priority over bounds.
- When not defined: upper address bits pass to dm_addr unchanged, memory aliases on addr[ADDR_BITS-1:2], and cause 11 is never produced.

Test Plan:
- Word round trip:
  - SW addr 0x10, data 0xDEADBEEF → dm_write high for 1 cycle.
  - Then LW 0x10 → next cycle rsp_valid = 1, rsp_data = 0xDEADBEEF.
- Byte store and loads, starting from word 0x10 = 0xDEADBEEF:
  - SB 0x13, data 0x000000AA → req_ready low 1 cycle, dm_read then dm_write, dm_wdata = 0xDEADBEAA.
  - LB 0x13 → 0xFFFFFFAA.
  - LBU 0x13 → 0x000000AA.
- Halfword store and loads:
  - SH 0x12, data 0x00001234 → word becomes 0xDEAD1234.
  - LH 0x10 → 0xFFFFDEAD.
  - LHU 0x12 → 0x00001234.
- Misalignment:
  - LW 0x11 → no dm_read/dm_write; next cycle exc_valid = 1, exc_cause = 01, exc_addr = 0x11.
  - SH 0x13 → exc_cause = 10.
- Reset during RMW: rst_n low while in RMW_WR of SB 0x10 → dm_write 0 immediately, state IDLE; a later LW 0x10 returns the unchanged word.
- Bounds check:
  - With macro defined: LW 0x400 → exc_valid, exc_cause = 11, exc_addr = 0x400.
  - Without macro: LW 0x400 → rsp_data equals contents of word 0.
